cmd_engine: RTL and testbench

CMD_ENGINE -- requirements
Module: cmd_engine

---
 rtl/cmd_pkg.sv | 40 ++++
 rtl/cmd_msg_rom.sv | 28 ++
 rtl/cmd_engine.sv | 174 +++++++++++++++++
 tb/tb_cmd_engine.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_pkg.sv
// Shared types and constants for the command-line engine.
// Help text exists only when CMD_ENGINE_HELP_EN is defined.
package cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_RESP,
        ST_SOLVE,
        ST_WAIT_ACK
    } state_t;

    localparam int CMD_MAX_LEN  = 32;
    localparam int RESP_MAX_LEN = 63;

    typedef enum logic [1:0] {
        MSG_EMPTY,
        MSG_NOT_FOUND,
        MSG_HELP
    } msg_id_t;

    localparam logic [7:0] ASC_NUL   = 8'h00;
    localparam logic [7:0] ASC_SPACE = 8'h20;
    localparam logic [7:0] ASC_C     = 8'h63;
    localparam logic [7:0] ASC_E     = 8'h65;
    localparam logic [7:0] ASC_H     = 8'h68;
    localparam logic [7:0] ASC_L     = 8'h6c;
    localparam logic [7:0] ASC_O     = 8'h6f;
    localparam logic [7:0] ASC_P     = 8'h70;

    localparam int NF_LEN = 17;
    localparam logic [8*NF_LEN-1:0] NF_TEXT = "command not found";

`ifdef CMD_ENGINE_HELP_EN
    localparam int HELP_LEN = 19;
    localparam logic [8*HELP_LEN-1:0] HELP_TEXT = "commands: echo help";
`endif

endpackage

// File: rtl/cmd_msg_rom.sv
// Fixed response messages: message ID + char index -> ASCII, 0 past the end.
// The help message is built only with CMD_ENGINE_HELP_EN.
import cmd_pkg::*;

module cmd_msg_rom (
    input  msg_id_t     msg_id,
    input  logic [5:0]  idx,
    output logic [7:0]  ch
);

    always_comb begin
        ch = ASC_NUL;
        case (msg_id)
            MSG_NOT_FOUND: begin
                if (idx < 6'(NF_LEN))
                    ch = 8'(NF_TEXT >> (8 * (NF_LEN - 1 - int'(idx))));
            end
`ifdef CMD_ENGINE_HELP_EN
            MSG_HELP: begin
                if (idx < 6'(HELP_LEN))
                    ch = 8'(HELP_TEXT >> (8 * (HELP_LEN - 1 - int'(idx))));
            end
`endif
            default: ch = ASC_NUL;
        endcase
    end

endmodule

// File: rtl/cmd_engine.sv
// Terminal command engine: pulls a line, decodes echo/help, streams a reply.
// Optional "help" command enabled by CMD_ENGINE_HELP_EN.
import cmd_pkg::*;

module cmd_engine (
    input  logic        clk,
    input  logic        rst,
    input  logic        line_ready,
    input  logic [5:0]  line_len,
    input  logic [7:0]  line_char,
    output logic        line_next,
    output logic        resp_ready,
    output logic [7:0]  resp_char,
    input  logic        resp_next,
    output logic        solved,
    input  logic        solved_ack,
    output logic        busy
);

    state_t      state;
    logic [5:0]  len_q;
    logic [5:0]  cnt;
    logic [5:0]  rptr;
    logic        gap;
    logic        src_echo;
    msg_id_t     src_msg;
    logic [7:0]  line_buf [CMD_MAX_LEN];

    logic        is_echo_pfx;
    logic        is_echo;
    msg_id_t     dec_msg;
    logic        use_echo;
    msg_id_t     use_msg;
    logic [5:0]  look_idx;
    logic [7:0]  echo_ch;
    logic [7:0]  rom_ch;
    logic [7:0]  look_ch;

    assign is_echo_pfx = (len_q >= 6'd5) &&
                         line_buf[0] == ASC_E && line_buf[1] == ASC_C &&
                         line_buf[2] == ASC_H && line_buf[3] == ASC_O &&
                         line_buf[4] == ASC_SPACE;

    assign is_echo = (len_q == 6'd4) &&
                     line_buf[0] == ASC_E && line_buf[1] == ASC_C &&
                     line_buf[2] == ASC_H && line_buf[3] == ASC_O;

`ifdef CMD_ENGINE_HELP_EN
    logic is_help;
    assign is_help = (len_q == 6'd4) &&
                     line_buf[0] == ASC_H && line_buf[1] == ASC_E &&
                     line_buf[2] == ASC_L && line_buf[3] == ASC_P;
`endif

    always_comb begin
        dec_msg = MSG_NOT_FOUND;
        if (is_echo)
            dec_msg = MSG_EMPTY;
`ifdef CMD_ENGINE_HELP_EN
        else if (is_help)
            dec_msg = MSG_HELP;
`endif
    end

    // DECODE looks up the first reply char; RESP looks one char ahead.
    always_comb begin
        use_echo = src_echo;
        use_msg  = src_msg;
        look_idx = rptr + 6'd1;
        if (state == ST_DECODE) begin
            use_echo = is_echo_pfx;
            use_msg  = dec_msg;
            look_idx = is_echo_pfx ? 6'd5 : 6'd0;
        end
    end

    assign echo_ch = (look_idx < len_q) ? line_buf[look_idx[4:0]] : ASC_NUL;
    assign look_ch = use_echo ? echo_ch : rom_ch;

    cmd_msg_rom u_rom (
        .msg_id (use_msg),
        .idx    (look_idx),
        .ch     (rom_ch)
    );

    always_ff @(posedge clk) begin
        if (state == ST_FETCH && !gap && cnt < len_q)
            line_buf[cnt[4:0]] <= line_char;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            len_q      <= '0;
            cnt        <= '0;
            rptr       <= '0;
            gap        <= 1'b0;
            src_echo   <= 1'b0;
            src_msg    <= MSG_EMPTY;
            line_next  <= 1'b0;
            resp_ready <= 1'b0;
            resp_char  <= ASC_NUL;
            solved     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            line_next <= 1'b0;
            solved    <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (line_ready) begin
                        len_q <= (line_len > 6'(CMD_MAX_LEN)) ?
                                 6'(CMD_MAX_LEN) : line_len;
                        cnt   <= '0;
                        gap   <= 1'b0;
                        busy  <= 1'b1;
                        state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (cnt < len_q) begin
                        if (!gap) begin
                            cnt       <= cnt + 6'd1;
                            line_next <= 1'b1;
                            gap       <= 1'b1;
                        end else begin
                            gap <= 1'b0;
                        end
                    end else if (!line_ready) begin
                        state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    rptr     <= is_echo_pfx ? 6'd5 : 6'd0;
                    src_echo <= is_echo_pfx;
                    src_msg  <= dec_msg;
                    if (len_q == 6'd0) begin
                        solved <= 1'b1;
                        state  <= ST_SOLVE;
                    end else begin
                        resp_ready <= 1'b1;
                        resp_char  <= look_ch;
                        state      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (resp_next) begin
                        if (resp_char != ASC_NUL) begin
                            rptr      <= rptr + 6'd1;
                            resp_char <= look_ch;
                        end else begin
                            resp_ready <= 1'b0;
                            solved     <= 1'b1;
                            state      <= ST_SOLVE;
                        end
                    end
                end
                ST_SOLVE: begin
                    state <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (solved_ack) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_engine.sv
// Directed bench for cmd_engine: table of command lines plus
// hand-written reset-during-fetch and busy-during-ack sequences.
`timescale 1ns/1ps

module tb_cmd_engine;

    logic        clk;
    logic        rst;
    logic        line_ready;
    logic [5:0]  line_len;
    logic [7:0]  line_char;
    logic        line_next;
    logic        resp_ready;
    logic [7:0]  resp_char;
    logic        resp_next;
    logic        solved;
    logic        solved_ack;
    logic        busy;

    int    applied = 0;
    int    miscmp  = 0;
    string tag     = "init";

    typedef struct {
        string cmd;
        int    len;
        int    pulls;
        bit    has_resp;
        string resp;
    } vec_t;

    vec_t vecs [12];

    cmd_engine dut (
        .clk        (clk),
        .rst        (rst),
        .line_ready (line_ready),
        .line_len   (line_len),
        .line_char  (line_char),
        .line_next  (line_next),
        .resp_ready (resp_ready),
        .resp_char  (resp_char),
        .resp_next  (resp_next),
        .solved     (solved),
        .solved_ack (solved_ack),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            miscmp++;
            $display("FAIL %s/%s: got %0d (0x%0h), expected %0d (0x%0h)",
                     tag, name, act, act, exp, exp);
        end
    endtask

    function automatic logic [7:0] ch_at(input string s, input int i);
        if (i < s.len())
            return s[i];
        return 8'h00;
    endfunction

    task automatic run_vec(input vec_t v);
        int lptr = 0;
        int npulse = 0;
        int last_pulse = 0;
        int gap_bad = 0;
        int ridx = 0;
        int nsolved = 0;
        int drop_cyc = -1;
        int solved_cyc = -1;
        int ack_at = 0;
        int unstable = 0;
        bit rdone = 0;
        bit rphase = 0;
        bit resp_seen = 0;
        bit acked = 0;
        bit done = 0;
        logic [7:0] hold = 8'h00;
        logic [7:0] expc;
        @(negedge clk);
        line_len   = 6'(v.len);
        line_ready = 1'b1;
        line_char  = ch_at(v.cmd, 0);
        for (int cyc = 0; cyc < 1000 && !done; cyc++) begin
            @(negedge clk);
            if (line_next) begin
                npulse++;
                if (npulse > 1 && cyc - last_pulse != 2)
                    gap_bad++;
                last_pulse = cyc;
                lptr++;
            end
            if (line_ready && lptr >= v.pulls && (v.pulls > 0 || cyc >= 2)) begin
                line_ready = 1'b0;
                drop_cyc   = cyc;
            end
            line_char = ch_at(v.cmd, lptr);
            if (resp_ready)
                resp_seen = 1;
            if (resp_next) begin
                resp_next = 1'b0;
                hold      = resp_char;
                rphase    = 1;
            end else if (resp_ready && !rdone) begin
                if (rphase && resp_char !== hold)
                    unstable++;
                expc = ch_at(v.resp, ridx);
                check($sformatf("resp_char[%0d]", ridx), 32'(resp_char),
                      32'(expc));
                if (expc == 8'h00 || ridx > 64)
                    rdone = 1;
                ridx++;
                resp_next = 1'b1;
            end
            if (solved) begin
                nsolved++;
                solved_cyc = cyc;
                ack_at     = cyc + 2;
            end
            if (solved_ack)
                solved_ack = 1'b0;
            else if (nsolved > 0 && !acked && cyc >= ack_at) begin
                solved_ack = 1'b1;
                acked      = 1;
            end
            if (acked && !solved_ack && !busy)
                done = 1;
        end
        line_ready = 1'b0;
        resp_next  = 1'b0;
        solved_ack = 1'b0;
        check("finished", 32'(done), 1);
        check("line_next_count", npulse, v.pulls);
        check("line_next_spacing", gap_bad, 0);
        check("solved_pulses", nsolved, 1);
        check("resp_complete", 32'(rdone), 32'(v.has_resp));
        check("resp_ready_seen", 32'(resp_seen), 32'(v.has_resp));
        check("resp_stable", unstable, 0);
        if (v.len == 0)
            check("len0_latency",
                  32'(solved_cyc > drop_cyc && solved_cyc - drop_cyc <= 3), 1);
        check("idle_outputs",
              32'({busy, resp_ready, line_next, solved, resp_char}), 0);
        if (!done) begin
            @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
        end
    endtask

    task automatic reset_mid_fetch();
        string s = "echo 123456789012345";
        int lptr = 0;
        bit hit = 0;
        tag = "rst_mid_fetch";
        @(negedge clk);
        line_len   = 6'd20;
        line_ready = 1'b1;
        line_char  = ch_at(s, 0);
        for (int cyc = 0; cyc < 100 && !hit; cyc++) begin
            @(negedge clk);
            if (line_next)
                lptr++;
            line_char = ch_at(s, lptr);
            if (lptr == 3)
                hit = 1;
        end
        check("reached_3_chars", 32'(hit), 1);
        check("busy_before_rst", 32'(busy), 1);
        #2;
        rst        = 1'b1;
        line_ready = 1'b0;
        #1;
        check("async_clear",
              32'({busy, resp_ready, line_next, solved, resp_char}), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_after_rst",
              32'({busy, resp_ready, line_next, solved, resp_char}), 0);
    endtask

    task automatic busy_during_ack();
        bit got_solved = 0;
        int bad = 0;
        tag = "wait_ack";
        @(negedge clk);
        line_len   = 6'd0;
        line_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        line_ready = 1'b0;
        for (int cyc = 0; cyc < 10 && !got_solved; cyc++) begin
            @(negedge clk);
            if (solved)
                got_solved = 1;
        end
        check("solved_seen", 32'(got_solved), 1);
        @(negedge clk);
        line_ready = 1'b1;
        line_len   = 6'd5;
        line_char  = 8'h65;
        resp_next  = 1'b1;
        @(negedge clk);
        line_ready = 1'b0;
        resp_next  = 1'b0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge clk);
            if (!busy || line_next || resp_ready || solved)
                bad++;
        end
        check("held_in_wait_ack", bad, 0);
        solved_ack = 1'b1;
        @(negedge clk);
        solved_ack = 1'b0;
        check("idle_after_ack", 32'(busy), 0);
        bad = 0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(negedge clk);
            if (busy || line_next)
                bad++;
        end
        check("pulse_not_latched", bad, 0);
        line_char = 8'h00;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{"echo hi", 7, 7, 1, "hi"};
        vecs[1]  = '{"", 0, 0, 0, ""};
        vecs[2]  = '{"ls", 2, 2, 1, "command not found"};
`ifdef CMD_ENGINE_HELP_EN
        vecs[3]  = '{"help", 4, 4, 1, "commands: echo help"};
`else
        vecs[3]  = '{"help", 4, 4, 1, "command not found"};
`endif
        vecs[4]  = '{"echo", 4, 4, 1, ""};
        vecs[5]  = '{"Echo hi", 7, 7, 1, "command not found"};
        vecs[6]  = '{" help", 5, 5, 1, "command not found"};
        vecs[7]  = '{"echo  x ", 8, 8, 1, " x "};
        vecs[8]  = '{"echo ", 5, 5, 1, ""};
        vecs[9]  = '{"echo abcdefghijklmnopqrstuvwxyz0", 40, 32, 1,
                     "abcdefghijklmnopqrstuvwxyz0"};
        vecs[10] = '{"echox", 5, 5, 1, "command not found"};
        vecs[11] = '{"echo ", 4, 4, 1, ""};

        clk        = 1'b0;
        rst        = 1'b0;
        line_ready = 1'b0;
        line_len   = 6'd0;
        line_char  = 8'h00;
        resp_next  = 1'b0;
        solved_ack = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        tag = "reset";
        check("outputs_in_reset",
              32'({busy, resp_ready, line_next, solved, resp_char}), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("outputs_after_reset",
              32'({busy, resp_ready, line_next, solved, resp_char}), 0);

        for (int i = 0; i < 12; i++) begin
            tag = $sformatf("vec%0d", i);
            run_vec(vecs[i]);
        end

        reset_mid_fetch();
        tag = "after_rst";
        run_vec(vecs[0]);

        busy_during_ack();
        tag = "after_wait_ack";
        run_vec(vecs[2]);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscmp);
        $finish;
    end

endmodule
